// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - LCD/VGA timing generator with pixel-request pipeline
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COLOR_W  = 8,
  parameter int LAT      = 2,
  parameter int XY_W     = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               pix_req,
  output logic [XY_W-1:0]    pix_x,
  output logic [XY_W-1:0]    pix_y,
  output logic               frame_start,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [COLOR_W-1:0] rgb_r,
  output logic [COLOR_W-1:0] rgb_g,
  output logic [COLOR_W-1:0] rgb_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XY_W-1:0] C_H_ACT  = XY_W'(H_ACTIVE);
  localparam logic [XY_W-1:0] C_HS_BEG = XY_W'(H_ACTIVE + H_FP);
  localparam logic [XY_W-1:0] C_HS_END = XY_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XY_W-1:0] C_H_LAST = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0] C_V_ACT  = XY_W'(V_ACTIVE);
  localparam logic [XY_W-1:0] C_VS_BEG = XY_W'(V_ACTIVE + V_FP);
  localparam logic [XY_W-1:0] C_VS_END = XY_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XY_W-1:0] C_V_LAST = XY_W'(V_TOTAL - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [XY_W-1:0]    r_h_cnt;
  logic [XY_W-1:0]    r_v_cnt;
  logic               w_run;
  logic               w_last;
  logic               w_req;
  logic               w_hs_i;
  logic               w_vs_i;
  logic               w_take;
  logic [LAT:0]       r_de_sr;
  logic [LAT:0]       r_hs_sr;
  logic [LAT:0]       r_vs_sr;
  logic [COLOR_W-1:0] r_rgb_r;
  logic [COLOR_W-1:0] r_rgb_g;
  logic [COLOR_W-1:0] r_rgb_b;

  assign w_last = (r_h_cnt == C_H_LAST) && (r_v_cnt == C_V_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and run qualifier; the first en=1 cycle in IDLE is already pixel (0,0)
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_run       = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (w_last && !en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // keep request-stage outputs quiet while reset is held even if en is high
    if (!rst_n) w_run = 1'b0;
  end

  // H/V position counters; held at 0 while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_run) begin
      if (r_h_cnt == C_H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end else begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end
  end

  assign w_req  = w_run && (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
  assign w_hs_i = w_run && (r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END);
  assign w_vs_i = w_run && (r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END);

  assign pix_req     = w_req;
  assign pix_x       = r_h_cnt;
  assign pix_y       = r_v_cnt;
  assign frame_start = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);

  generate
    if (LAT == 0) begin : g_lat0
      assign w_take = w_req;
      // Single register stage: sync/de leave one cycle after the request
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_de_sr <= '0;
          r_hs_sr <= '0;
          r_vs_sr <= '0;
        end else begin
          r_de_sr <= w_req;
          r_hs_sr <= w_hs_i;
          r_vs_sr <= w_vs_i;
        end
      end
    end else begin : g_latn
      // w_take marks the cycle where the render data for an earlier request arrives
      assign w_take = r_de_sr[LAT-1];
      // Delay line so sync/de come out LAT+1 cycles after the request, beside the colour
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_de_sr <= '0;
          r_hs_sr <= '0;
          r_vs_sr <= '0;
        end else begin
          r_de_sr <= {r_de_sr[LAT-1:0], w_req};
          r_hs_sr <= {r_hs_sr[LAT-1:0], w_hs_i};
          r_vs_sr <= {r_vs_sr[LAT-1:0], w_vs_i};
        end
      end
    end
  endgenerate

  // Capture colour only for requested pixels so blanking is always black
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb_r <= '0;
      r_rgb_g <= '0;
      r_rgb_b <= '0;
    end else if (w_take) begin
      r_rgb_r <= pix_r;
      r_rgb_g <= pix_g;
      r_rgb_b <= pix_b;
    end else begin
      r_rgb_r <= '0;
      r_rgb_g <= '0;
      r_rgb_b <= '0;
    end
  end

  assign de    = r_de_sr[LAT];
  assign hs    = r_hs_sr[LAT] ^ ~HS_POL;
  assign vs    = r_vs_sr[LAT] ^ ~VS_POL;
  assign rgb_r = r_rgb_r;
  assign rgb_g = r_rgb_g;
  assign rgb_b = r_rgb_b;

endmodule
